// File: rtl/mgt_01_mul_arbiter.sv
// Round-robin arbiter letting the integer MUL (id 0) and FPU (id 1) requesters share one
// multi-cycle signed multiplier, with requester-0 flush and a RUN-phase watchdog.
module mgt_01_mul_arbiter #(
  parameter int XLEN = 32,
  parameter int WDOG = 24
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req0_valid_i,
  output logic              req0_ready_o,
  input  logic [XLEN-1:0]   req0_multiplier_i,
  input  logic [XLEN-1:0]   req0_multiplicand_i,
  input  logic              req1_valid_i,
  output logic              req1_ready_o,
  input  logic [XLEN-1:0]   req1_multiplier_i,
  input  logic [XLEN-1:0]   req1_multiplicand_i,
  input  logic              flush0_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic              rsp_id_o,
  output logic [2*XLEN-1:0] rsp_result_o,
  output logic              rsp_err_o,
  output logic [XLEN-1:0]   mul_multiplier_o,
  output logic [XLEN-1:0]   mul_multiplicand_o,
  output logic              mul_clk_en_o,
  output logic              mul_rst_n_o,
  input  logic [2*XLEN-1:0] mul_result_i,
  input  logic              mul_valid_i,
  output logic              busy_o
);

  localparam int CW = $clog2(WDOG + 1);

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_RUN, S_RESP} state_t;

  state_t                   state, state_nxt;
  logic [1:0]               init_cnt;
  logic [CW-1:0]            run_cnt;
  logic                     rr_ptr;
  logic                     sel;
  logic                     grant;
  logic                     flushed;
  logic                     to_init;
  logic                     discard;
  logic                     wdog_hit;
  logic signed [XLEN-1:0]   a_q;
  logic signed [XLEN-1:0]   b_q;
  logic                     id_q;
  logic [2*XLEN-1:0]        result_q;
  logic                     err_q;

  // rr_ptr names the requester preferred when both are valid
  always_comb begin
    sel = rr_ptr;
    if (req0_valid_i && req1_valid_i) sel = rr_ptr;
    else if (req1_valid_i)            sel = 1'b1;
    else if (req0_valid_i)            sel = 1'b0;
  end

  assign grant    = (state == S_IDLE) && (sel ? req1_valid_i : req0_valid_i);
  assign discard  = flushed || (flush0_i && !id_q);
  assign wdog_hit = (run_cnt == CW'(WDOG - 1));

  assign mul_multiplier_o   = a_q;
  assign mul_multiplicand_o = b_q;
  assign rsp_id_o           = id_q;
  assign rsp_result_o       = result_q;
  assign rsp_err_o          = err_q;

  always_comb begin
    state_nxt    = state;
    req0_ready_o = 1'b0;
    req1_ready_o = 1'b0;
    mul_clk_en_o = 1'b0;
    mul_rst_n_o  = 1'b1;
    rsp_valid_o  = 1'b0;
    busy_o       = 1'b1;
    case (state)
      S_INIT: begin
        mul_rst_n_o = (init_cnt == 2'd2);
        if (init_cnt == 2'd2) state_nxt = S_IDLE;
      end
      S_IDLE: begin
        busy_o       = 1'b0;
        req0_ready_o = !sel;
        req1_ready_o = sel;
        if (grant) state_nxt = S_RUN;
      end
      S_RUN: begin
        // enable stays high on the completion edge so the multiplier parks in idle
        mul_clk_en_o = 1'b1;
        if (mul_valid_i)   state_nxt = discard ? S_IDLE : S_RESP;
        else if (wdog_hit) state_nxt = discard ? S_INIT : S_RESP;
      end
      S_RESP: begin
        rsp_valid_o = 1'b1;
        if (rsp_ready_i) state_nxt = to_init ? S_INIT : S_IDLE;
      end
      default: state_nxt = S_INIT;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= S_INIT;
      init_cnt <= 2'd0;
      run_cnt  <= '0;
      rr_ptr   <= 1'b0;
      flushed  <= 1'b0;
      to_init  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      id_q     <= 1'b0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state    <= state_nxt;
      init_cnt <= (state == S_INIT && init_cnt != 2'd2) ? init_cnt + 2'd1 : 2'd0;
      run_cnt  <= (state == S_RUN) ? run_cnt + CW'(1) : '0;
      if (grant) begin
        a_q     <= sel ? req1_multiplier_i   : req0_multiplier_i;
        b_q     <= sel ? req1_multiplicand_i : req0_multiplicand_i;
        id_q    <= sel;
        rr_ptr  <= !sel;
        flushed <= 1'b0;
        to_init <= 1'b0;
      end
      if (state == S_RUN && flush0_i && !id_q) flushed <= 1'b1;
      if (state == S_RUN && mul_valid_i) begin
        result_q <= mul_result_i;
        err_q    <= 1'b0;
      end else if (state == S_RUN && wdog_hit && !discard) begin
        // a timed-out operation answers with an error, then the multiplier is re-initialised
        result_q <= '0;
        err_q    <= 1'b1;
        to_init  <= 1'b1;
      end
    end
  end

endmodule
